pc_fetch_stage: RTL and testbench

Instruction-fetch stage of the pipelined MIPS datapath. Holds the program counter register, drives `PCResult` into the PC+4 adder, and consumes the adder's `PCAddResult`. Selects the next PC from sequential, branch and jump sources under hazard-unit stall control. Captures the fetched instruction and PC+4 into the IF/ID pipeline register, with flush on redirect.

---
 rtl/pc_fetch_stage.sv | 58 +++++
 tb/tb_pc_fetch_stage.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/pc_fetch_stage.sv
// Instruction-fetch stage: PC register, next-PC selection (branch > jump > stall > sequential),
// IF/ID pipeline register with flush on redirect, sticky misalignment flag and fetch counter.
module pc_fetch_stage #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] PCAddResult,
  output logic [31:0] PCResult,
  input  logic [31:0] Instruction,
  input  logic        Stall,
  input  logic        BranchTaken,
  input  logic [31:0] BranchTarget,
  input  logic        Jump,
  input  logic [31:0] JumpTarget,
  output logic [31:0] IFID_Instr,
  output logic [31:0] IFID_PCPlus4,
  output logic        IFID_Valid,
  output logic        MisalignErr,
  output logic [31:0] FetchCount
);

  logic        redirect;
  logic [31:0] redirect_target;

  // The branch belongs to the older instruction, so it outranks a jump seen in the same cycle.
  always_comb begin
    redirect        = BranchTaken | Jump;
    redirect_target = BranchTaken ? BranchTarget : JumpTarget;
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      PCResult     <= RESET_PC;
      IFID_Instr   <= 32'h0;
      IFID_PCPlus4 <= 32'h0;
      IFID_Valid   <= 1'b0;
      MisalignErr  <= 1'b0;
      FetchCount   <= 32'h0;
    end else if (redirect) begin
      // Redirect wins over stall; the wrong-path fetch is dropped as a bubble.
      PCResult     <= {redirect_target[31:2], 2'b00};
      IFID_Instr   <= 32'h0;
      IFID_PCPlus4 <= 32'h0;
      IFID_Valid   <= 1'b0;
      if (redirect_target[1:0] != 2'b00) begin
        MisalignErr <= 1'b1;
      end
    end else if (!Stall) begin
      PCResult     <= PCAddResult;
      IFID_Instr   <= Instruction;
      IFID_PCPlus4 <= PCAddResult;
      IFID_Valid   <= 1'b1;
      FetchCount   <= FetchCount + 32'd1;
    end
  end

endmodule

// File: tb/tb_pc_fetch_stage.sv
// Directed bench for pc_fetch_stage: a behavioural model pushes expected outputs per edge,
// popped and compared just after the edge, plus explicit checks of the key scenario values.
module tb_pc_fetch_stage;

  logic        Clk = 1'b0;
  logic        Reset;
  logic [31:0] PCAddResult;
  logic [31:0] PCResult;
  logic [31:0] Instruction;
  logic        Stall;
  logic        BranchTaken;
  logic [31:0] BranchTarget;
  logic        Jump;
  logic [31:0] JumpTarget;
  logic [31:0] IFID_Instr;
  logic [31:0] IFID_PCPlus4;
  logic        IFID_Valid;
  logic        MisalignErr;
  logic [31:0] FetchCount;

  int vectors = 0;
  int miscompares = 0;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] pc4;
    logic        valid;
    logic        mis;
    logic [31:0] cnt;
  } exp_t;

  exp_t sb_q[$];

  logic [31:0] m_pc, m_instr, m_pc4, m_cnt;
  logic        m_valid, m_mis;

  always #5 Clk = ~Clk;

  // PC adder and instruction memory (word at address a reads back a)
  assign PCAddResult = PCResult + 32'd4;
  assign Instruction = PCResult;

  pc_fetch_stage #(.RESET_PC(32'h0000_0000)) dut (
    .Clk(Clk), .Reset(Reset), .PCAddResult(PCAddResult), .PCResult(PCResult),
    .Instruction(Instruction), .Stall(Stall), .BranchTaken(BranchTaken),
    .BranchTarget(BranchTarget), .Jump(Jump), .JumpTarget(JumpTarget),
    .IFID_Instr(IFID_Instr), .IFID_PCPlus4(IFID_PCPlus4), .IFID_Valid(IFID_Valid),
    .MisalignErr(MisalignErr), .FetchCount(FetchCount)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    vectors++;
    assert (obs === expv) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask

  // Advance one edge: model the expected next state from current inputs, then compare.
  task automatic step();
    exp_t e;
    logic [31:0] tgt;
    if (!Reset) begin
      m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
    end else if (BranchTaken || Jump) begin
      tgt = BranchTaken ? BranchTarget : JumpTarget;
      m_pc = tgt & 32'hFFFF_FFFC;
      m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0;
      if (tgt[1:0] != 2'b00) m_mis = 1'b1;
    end else if (!Stall) begin
      m_instr = m_pc;
      m_pc4   = m_pc + 32'd4;
      m_pc    = m_pc + 32'd4;
      m_valid = 1'b1;
      m_cnt   = m_cnt + 32'd1;
    end
    e.pc = m_pc; e.instr = m_instr; e.pc4 = m_pc4; e.valid = m_valid; e.mis = m_mis; e.cnt = m_cnt;
    sb_q.push_back(e);
    @(posedge Clk);
    #1;
    e = sb_q.pop_front();
    chk("pc",    PCResult,            e.pc);
    chk("instr", IFID_Instr,          e.instr);
    chk("pc4",   IFID_PCPlus4,        e.pc4);
    chk("valid", {31'h0, IFID_Valid}, {31'h0, e.valid});
    chk("mis",   {31'h0, MisalignErr},{31'h0, e.mis});
    chk("cnt",   FetchCount,          e.cnt);
  endtask

  task automatic idle_inputs();
    Stall = 1'b0; BranchTaken = 1'b0; Jump = 1'b0;
    BranchTarget = 32'h0; JumpTarget = 32'h0;
  endtask

  initial begin
    m_pc = 32'h0; m_instr = 32'h0; m_pc4 = 32'h0; m_valid = 1'b0; m_mis = 1'b0; m_cnt = 32'h0;
    Reset = 1'b0;
    idle_inputs();
    step();
    chk("rst_pc", PCResult, 32'h0);
    chk("rst_valid", {31'h0, IFID_Valid}, 32'h0);

    // free-run to PC 0x10
    Reset = 1'b1;
    repeat (4) step();
    chk("run_pc", PCResult, 32'h10);
    chk("run_ifid", IFID_Instr, 32'h0C);

    // three-cycle stall at PC 0x10
    Stall = 1'b1;
    repeat (3) begin
      step();
      chk("stall_pc", PCResult, 32'h10);
      chk("stall_pc4", IFID_PCPlus4, 32'h10);
      chk("stall_cnt", FetchCount, 32'd4);
    end
    Stall = 1'b0;
    step();
    chk("unstall_instr", IFID_Instr, 32'h10);
    chk("cnt5", FetchCount, 32'd5);

    // branch and jump together: branch wins
    BranchTaken = 1'b1; BranchTarget = 32'h100; Jump = 1'b1; JumpTarget = 32'h200;
    step();
    chk("bj_pc", PCResult, 32'h100);
    chk("bj_bubble", {31'h0, IFID_Valid}, 32'h0);
    idle_inputs();
    step();
    chk("bj_pc4", IFID_PCPlus4, 32'h104);

    // jump during stall
    Stall = 1'b1; Jump = 1'b1; JumpTarget = 32'h40;
    step();
    chk("js_pc", PCResult, 32'h40);
    chk("js_flush", {31'h0, IFID_Valid}, 32'h0);
    idle_inputs();
    step();

    // misaligned branch target, then sticky for 10 cycles
    BranchTaken = 1'b1; BranchTarget = 32'h103;
    step();
    chk("mis_pc", PCResult, 32'h100);
    chk("mis_set", {31'h0, MisalignErr}, 32'h1);
    idle_inputs();
    for (int i = 0; i < 10; i++) begin
      Stall = $urandom_range(0, 1) == 1;
      step();
    end
    chk("mis_sticky", {31'h0, MisalignErr}, 32'h1);

    // reset in the same cycle as a taken branch
    Stall = 1'b0; BranchTaken = 1'b1; BranchTarget = 32'h300; Reset = 1'b0;
    step();
    chk("mr_pc", PCResult, 32'h0);
    chk("mr_mis", {31'h0, MisalignErr}, 32'h0);
    chk("mr_cnt", FetchCount, 32'h0);
    idle_inputs();
    Reset = 1'b1;

    // mixed random traffic
    for (int i = 0; i < 30; i++) begin
      Stall        = $urandom_range(0, 3) == 0;
      BranchTaken  = $urandom_range(0, 7) == 0;
      Jump         = $urandom_range(0, 7) == 0;
      BranchTarget = $urandom;
      JumpTarget   = $urandom;
      step();
    end
    idle_inputs();
    step();

    // counter wrap
    dut.FetchCount = 32'hFFFF_FFFF;
    m_cnt = 32'hFFFF_FFFF;
    step();
    chk("wrap", FetchCount, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule
